// File: rtl/fifo_stream_reader.sv
// Read-side adapter for fifo_sync: turns the FIFO's r_en/data_out port (one-cycle
// read latency) into a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_r_en_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic [CNT_WIDTH-1:0]  word_cnt_o,
  output logic                  idle_o
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [1:0]            occ;
  logic                  inflight;
  logic [BW-1:0]         beat;
  logic [CNT_WIDTH-1:0]  word_cnt;
  logic [DATA_WIDTH-1:0] head_q, tail_q;
  logic                  accept;
  logic [2:0]            pending;

  assign m_valid_o = (occ != 2'd0);
  assign accept    = m_valid_o & m_ready_i;

  // Words that will occupy the buffer after this edge, before any new pop;
  // a pop is allowed only if its word is guaranteed a free slot on capture.
  assign pending     = {1'b0, occ} + {2'b0, inflight} - {2'b0, accept};
  assign fifo_r_en_o = resetn_i & ~fifo_empty_i & (pending <= 3'd1);

  assign m_data_o   = head_q;
  assign m_last_o   = m_valid_o & (beat == LAST_BEAT);
  assign word_cnt_o = word_cnt;
  assign idle_o     = (occ == 2'd0) & ~inflight & fifo_empty_i;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      beat     <= '0;
      word_cnt <= '0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      inflight <= fifo_r_en_o;
      // inflight doubles as the capture strobe: the popped word is on fifo_data_i now
      case ({inflight, accept})
        2'b10: begin
          if (occ == 2'd0) head_q <= fifo_data_i;
          else             tail_q <= fifo_data_i;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head_q <= tail_q;
            tail_q <= fifo_data_i;
          end else begin
            head_q <= fifo_data_i;
          end
        end
        default: ;
      endcase
      if (accept) begin
        word_cnt <= word_cnt + 1'b1;
        beat     <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
    end
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter for `fifo_sync`: pops words from the FIFO's `r_en`/`data_out`/`fifo_empty` port and presents them downstream as a valid/ready stream. A 2-entry output buffer hides the FIFO's one-cycle read latency, so the stream sustains one word per cycle. The block also tags bursts with `m_last_o` and counts delivered words. It sits between `fifo_sync` and any consumer that applies backpressure.

## Interface
- `DATA_WIDTH`, 8: word width; must match `fifo_sync`.
- `BURST_LEN`, 4: `m_last_o` marks every BURST_LEN-th delivered word; must be ≥1.
- `CNT_WIDTH`, 16: width of `word_cnt_o`.

- `clk_i` in 1: single clock; all logic on rising edge.
- `resetn_i` in 1: reset, asynchronous, active-low.
- `fifo_data_i` in DATA_WIDTH: from `fifo_sync` `data_out`.
- `fifo_empty_i` in 1: from `fifo_sync` `fifo_empty`.
- `fifo_r_en_o` out 1: to `fifo_sync` `r_en`. Combinational.
- `m_data_o` out DATA_WIDTH: stream data (buffer head, registered).
- `m_valid_o` out 1: stream valid (registered).
- `m_ready_i` in 1: downstream ready.
- `m_last_o` out 1: the current word ends a burst.
- `word_cnt_o` out CNT_WIDTH: count of accepted words; wraps modulo 2^CNT_WIDTH.
- `idle_o` out 1: nothing is buffered, nothing is in flight, and the FIFO is empty. Combinational.

## Operation
- **FIFO read contract.**
  - A pop occurs on an edge where `fifo_r_en_o=1` and `fifo_empty_i=0`.
  - The popped word is valid on `fifo_data_i` during the following cycle.
  - It is captured at the next edge.
- **State.**
  - `occ`: buffer occupancy, 0..2.
  - `inflight`: 0/1, set on the edge of a pop.
  - `beat`: position in the current burst, 0..BURST_LEN-1.
  - `word_cnt`.
- **Handshake.** An accept occurs on any edge with `m_valid_o & m_ready_i`.
- **Issue rule.**
  - `fifo_r_en_o = resetn_i & ~fifo_empty_i & ((occ + inflight - accept) ≤ 1)`.
  - The buffer can never overflow.
  - `fifo_r_en_o` is never high while `fifo_empty_i=1`, so there is no FIFO underflow.
- **Buffer.**
  - FIFO order.
  - A capture writes at the tail; an accept removes the head.
  - Capture and accept on the same edge leave `occ` unchanged.
  - The head shifts if needed.
- **Stream outputs.**
  - `m_valid_o = (occ≠0)`.
  - While `m_valid_o=1` and no accept occurs, `m_data_o` and `m_last_o` are held stable.
  - `m_valid_o` never drops without an accept.
  - `m_ready_i` may toggle freely.
- **Burst tagging.**
  - `m_last_o = m_valid_o & (beat == BURST_LEN-1)`.
  - On accept, `beat` increments and wraps to 0 after BURST_LEN-1.
  - BURST_LEN=1 means `m_last_o = m_valid_o`.
- **Counter.** `word_cnt_o` increments on accept and wraps from all-ones to 0.

## Timing
- **Reset values.**
  - `m_valid_o=0`, `m_data_o=0`, `m_last_o=0`, `word_cnt_o=0`.
  - `occ`, `inflight` and `beat` are 0.
  - `fifo_r_en_o=0` while `resetn_i=0`.
  - `idle_o = fifo_empty_i`.
- **Latency.** If `fifo_empty_i` falls in cycle c with the buffer empty:
  - `fifo_r_en_o=1` in cycle c.
  - Data is captured at the end of c+1.
  - `m_valid_o=1` in cycle c+2.
- **Throughput.** With `m_ready_i` held at 1 and the FIFO non-empty, the block delivers 1 word per cycle after the first word. Steady state is `occ=1`, `inflight=1`.
- **Backpressure.**
  - With `m_ready_i=0`, at most 2 words are popped (occ=2) and `fifo_r_en_o` then stays 0.
  - When `m_ready_i` rises, the next pop issues in that same cycle.
- **FIFO drains mid-stream.**
  - The in-flight word is still captured.
  - `m_valid_o` drops after the buffer empties.
  - `idle_o` rises only when `occ=0`, `inflight=0` and `fifo_empty_i=1`.
- **Reset mid-operation.**
  - All state clears asynchronously.
  - Buffered and in-flight words are discarded; `fifo_sync` must be reset concurrently.
  - The first cycle after release behaves as after power-up.

## Test plan
- **Reset check.** Assert reset with the FIFO holding 3 words, then release. Required response:
  - During reset: `m_valid_o=0`, `word_cnt_o=0`, `fifo_r_en_o=0`.
  - First `m_valid_o` at the 2nd cycle after the first `fifo_r_en_o`.
- **Streaming.** Write 20 words 0x00..0x13 into the FIFO and hold `m_ready_i=1`. Required response:
  - 20 consecutive accepts with no bubble after the first.
  - Data in order.
  - `m_last_o` on words 3, 7, 11, 15, 19 (BURST_LEN=4).
  - `word_cnt_o=20`.
- **Backpressure.** Fill the FIFO with 8 words and hold `m_ready_i=0` for 10 cycles. Required response:
  - Exactly 2 pops.
  - `m_data_o` holds word 0.
  - Then release `m_ready_i`: all 8 words arrive in order with none lost or duplicated.
- **Random ready.** Drive 200 random words and toggle `m_ready_i` randomly. Required response:
  - The output sequence equals the input sequence.
  - `m_data_o` and `m_last_o` are stable while stalled.
  - `fifo_r_en_o & fifo_empty_i` is never true.
- **Wrap.** Use CNT_WIDTH=4 and stream 18 words. Required response: `word_cnt_o` reads 15 then 0, and ends at 2.
- **Reset mid-burst.** Assert reset with `occ=2` and `inflight=1`. Required response: all outputs at reset values immediately (asynchronous), and `idle_o=1` once the FIFO is also reset.
